// File: rtl/q_update_sched_pkg.sv
// Shared types and constants for the Q-update sequencing controller:
// FSM encoding, datapath widths and index helpers used by the top and the step counter.
package q_update_sched_pkg;

    localparam int NUM_ACTIONS = 6;
    localparam int NUM_STATES  = 6;
    localparam int Q_W         = 24;
    localparam int IDX_W       = 3;
    localparam int STEP_W      = 16;

    localparam logic [IDX_W-1:0] ACT_LIMIT   = IDX_W'(NUM_ACTIONS);
    localparam logic [IDX_W-1:0] STATE_LIMIT = IDX_W'(NUM_STATES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_WAIT = 3'd2,
        ST_UPD  = 3'd3,
        ST_DONE = 3'd4
    } sched_state_t;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx,
                                    input logic [IDX_W-1:0] limit);
        idx_ok = (idx < limit);
    endfunction

    // Out-of-range actions map to an all-zero strobe so no EN block is touched.
    function automatic logic [NUM_ACTIONS-1:0] action_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_ACTIONS-1:0] base;
        base = NUM_ACTIONS'(1);
        action_onehot = idx_ok(idx, ACT_LIMIT) ? (base << idx) : '0;
    endfunction

endpackage

// File: rtl/q_update_sched_step_counter.sv
// Per-episode step counter: wraps to zero after MAX_STEPS completed steps and
// raises a one-cycle episode_end pulse on the wrapping step; clr has priority.
module q_update_sched_step_counter
    import q_update_sched_pkg::*;
#(
    parameter logic [STEP_W-1:0] MAX_STEPS = 16'd1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              clr,
    output logic [STEP_W-1:0] step_cnt,
    output logic              episode_end
);

    localparam logic [STEP_W-1:0] LAST_STEP = MAX_STEPS - STEP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt    <= '0;
            episode_end <= 1'b0;
        end else begin
            episode_end <= 1'b0;
            if (clr) begin
                step_cnt <= '0;
            end else if (step) begin
                if (step_cnt == LAST_STEP) begin
                    step_cnt    <= '0;
                    episode_end <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + STEP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/q_update_sched.sv
// Sequencer for the shared gamma-scaling path: selects the Max_Q mux input, waits for
// the multiplier, captures gamma*maxQ and strobes the EN block owning the current action.
module q_update_sched
    import q_update_sched_pkg::*;
#(
    parameter int                MUL_LAT   = 1,
    parameter logic [STEP_W-1:0] MAX_STEPS = 16'd1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [IDX_W-1:0]       next_state,
    input  logic [IDX_W-1:0]       cur_action,
    input  logic                   clr_cnt,
    input  logic [Q_W-1:0]         gamma_maxQ,
    output logic [IDX_W-1:0]       S_to_EN,
    output logic [Q_W-1:0]         target_q,
    output logic [NUM_ACTIONS-1:0] upd_en,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [STEP_W-1:0]      step_cnt,
    output logic                   episode_end
);

    localparam int               WAIT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MUL_LAT - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [IDX_W-1:0]  act_idx;
    logic              ns_bad;
    logic              act_bad;
    logic              accept;
    logic              wait_over;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wait_over = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SEL;
                end
            end
            ST_SEL:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    wait_over = 1'b1;
                    state_nxt = ST_UPD;
                end
            end
            ST_UPD:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every output is a flop loaded on the transition that enters the state owning it,
    // so S_to_EN is valid throughout SEL and done/err line up with the step count update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_to_EN  <= '0;
            target_q <= '0;
            upd_en   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wait_cnt <= '0;
            act_idx  <= '0;
            ns_bad   <= 1'b0;
            act_bad  <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= 1'b0;
            err  <= 1'b0;
            if (accept) begin
                S_to_EN <= idx_ok(next_state, STATE_LIMIT) ? next_state : '0;
                act_idx <= cur_action;
                ns_bad  <= !idx_ok(next_state, STATE_LIMIT);
                act_bad <= !idx_ok(cur_action, ACT_LIMIT);
            end
            if (state == ST_SEL) begin
                wait_cnt <= WAIT_LOAD;
            end
            if (state == ST_WAIT && !wait_over) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (wait_over) begin
                target_q <= gamma_maxQ;
                upd_en   <= action_onehot(act_idx);
            end
            if (state == ST_UPD) begin
                upd_en <= '0;
                done   <= 1'b1;
                err    <= ns_bad | act_bad;
            end
        end
    end

    q_update_sched_step_counter #(
        .MAX_STEPS(MAX_STEPS)
    ) u_step_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (state == ST_UPD),
        .clr        (clr_cnt),
        .step_cnt   (step_cnt),
        .episode_end(episode_end)
    );

endmodule

// File: tb/tb_q_update_sched.sv
// Directed bench for q_update_sched (MUL_LAT=1, MAX_STEPS=3): hand-computed expectations
// checked with immediate assertions, one linear sequence of steps.
module tb_q_update_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  next_state;
    logic [2:0]  cur_action;
    logic        clr_cnt;
    logic [23:0] gamma_maxQ;
    logic [2:0]  S_to_EN;
    logic [23:0] target_q;
    logic [5:0]  upd_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] step_cnt;
    logic        episode_end;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    q_update_sched #(
        .MUL_LAT  (1),
        .MAX_STEPS(16'd3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .next_state (next_state),
        .cur_action (cur_action),
        .clr_cnt    (clr_cnt),
        .gamma_maxQ (gamma_maxQ),
        .S_to_EN    (S_to_EN),
        .target_q   (target_q),
        .upd_en     (upd_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .step_cnt   (step_cnt),
        .episode_end(episode_end)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One full update; the indices are scrambled after sampling and start is
    // pulsed while busy, neither of which may disturb the sequence.
    task automatic applyStimulus(input string tag, input logic [2:0] ns, input logic [2:0] act,
                                 input logic [23:0] gq, input logic clr_at_upd,
                                 input logic [2:0] exp_sel, input logic [5:0] exp_upd,
                                 input logic exp_err, input logic [15:0] exp_cnt,
                                 input logic exp_ep);
        next_state = ns;
        cur_action = act;
        gamma_maxQ = gq;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        next_state = ns ^ 3'd1;
        cur_action = act ^ 3'd1;
        checkOutput({tag, ".sel"}, 32'(S_to_EN), 32'(exp_sel));
        checkOutput({tag, ".busy1"}, 32'(busy), 32'd1);
        checkOutput({tag, ".done1"}, 32'(done), 32'd0);
        tick();
        start = 1'b1;
        checkOutput({tag, ".upd_wait"}, 32'(upd_en), 32'd0);
        checkOutput({tag, ".sel_hold"}, 32'(S_to_EN), 32'(exp_sel));
        tick();
        clr_cnt = clr_at_upd;
        checkOutput({tag, ".upd_en"}, 32'(upd_en), 32'(exp_upd));
        checkOutput({tag, ".target_q"}, 32'(target_q), 32'(gq));
        tick();
        start   = 1'b0;
        clr_cnt = 1'b0;
        checkOutput({tag, ".done"}, 32'(done), 32'd1);
        checkOutput({tag, ".err"}, 32'(err), 32'(exp_err));
        checkOutput({tag, ".step_cnt"}, 32'(step_cnt), 32'(exp_cnt));
        checkOutput({tag, ".episode_end"}, 32'(episode_end), 32'(exp_ep));
        checkOutput({tag, ".upd_off"}, 32'(upd_en), 32'd0);
        tick();
        checkOutput({tag, ".done_off"}, 32'(done), 32'd0);
        checkOutput({tag, ".err_off"}, 32'(err), 32'd0);
        checkOutput({tag, ".ep_off"}, 32'(episode_end), 32'd0);
        checkOutput({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int last_done;
        int ep_cnt;

        rst_n      = 1'b0;
        start      = 1'b0;
        clr_cnt    = 1'b0;
        next_state = 3'd0;
        cur_action = 3'd0;
        gamma_maxQ = 24'h0;
        tick();
        tick();
        checkOutput("rst.S_to_EN", 32'(S_to_EN), 32'd0);
        checkOutput("rst.target_q", 32'(target_q), 32'd0);
        checkOutput("rst.upd_en", 32'(upd_en), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.err", 32'(err), 32'd0);
        checkOutput("rst.step_cnt", 32'(step_cnt), 32'd0);
        checkOutput("rst.episode_end", 32'(episode_end), 32'd0);
        rst_n = 1'b1;
        tick();

        applyStimulus("t1", 3'd2, 3'd4, 24'h3F4000, 1'b0, 3'd2, 6'b010000, 1'b0, 16'd1, 1'b0);
        applyStimulus("t2_bad_ns", 3'd7, 3'd1, 24'h000123, 1'b0, 3'd0, 6'b000010, 1'b1, 16'd2, 1'b0);

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checkOutput("clr_idle.step_cnt", 32'(step_cnt), 32'd0);
        checkOutput("clr_idle.episode_end", 32'(episode_end), 32'd0);

        applyStimulus("t3_bad_act", 3'd3, 3'd6, 24'h0ABCDE, 1'b0, 3'd3, 6'b000000, 1'b1, 16'd1, 1'b0);

        // start held high: done at cycles 4, 9, 14; count goes 1 -> 2 -> 0 (wrap) -> 1.
        next_state = 3'd5;
        cur_action = 3'd5;
        gamma_maxQ = 24'h000042;
        start      = 1'b1;
        done_cnt   = 0;
        first_done = 0;
        last_done  = 0;
        ep_cnt     = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
                if (last_done != 0) checkOutput("held.spacing", 32'(c - last_done), 32'd5);
                last_done = c;
            end
            if (episode_end) ep_cnt++;
        end
        start = 1'b0;
        checkOutput("held.dones", 32'(done_cnt), 32'd3);
        checkOutput("held.first_done", 32'(first_done), 32'd4);
        checkOutput("held.episodes", 32'(ep_cnt), 32'd1);
        checkOutput("held.step_cnt", 32'(step_cnt), 32'd1);

        // Reset asserted during WAIT: everything drops immediately, nothing follows.
        next_state = 3'd4;
        cur_action = 3'd2;
        gamma_maxQ = 24'h555555;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rstw.busy", 32'(busy), 32'd0);
        checkOutput("rstw.S_to_EN", 32'(S_to_EN), 32'd0);
        checkOutput("rstw.target_q", 32'(target_q), 32'd0);
        checkOutput("rstw.step_cnt", 32'(step_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("rstw.no_done", 32'(done), 32'd0);
            checkOutput("rstw.no_upd", 32'(upd_en), 32'd0);
            checkOutput("rstw.idle", 32'(busy), 32'd0);
        end

        applyStimulus("t4", 3'd5, 3'd0, 24'h7FFFFF, 1'b0, 3'd5, 6'b000001, 1'b0, 16'd1, 1'b0);
        applyStimulus("t5", 3'd1, 3'd3, 24'h100001, 1'b0, 3'd1, 6'b001000, 1'b0, 16'd2, 1'b0);
        applyStimulus("t6_clr", 3'd4, 3'd2, 24'h0000FF, 1'b1, 3'd4, 6'b000100, 1'b0, 16'd0, 1'b0);
        applyStimulus("t7", 3'd0, 3'd5, 24'h800000, 1'b0, 3'd0, 6'b100000, 1'b0, 16'd1, 1'b0);
        applyStimulus("t8", 3'd2, 3'd1, 24'h00A5A5, 1'b0, 3'd2, 6'b000010, 1'b0, 16'd2, 1'b0);
        applyStimulus("t9_wrap", 3'd3, 3'd0, 24'h123456, 1'b0, 3'd3, 6'b000001, 1'b0, 16'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/q_update_sched.md
# q_update_sched

Sequencing controller for the shared gamma-scaling path of the parallel Q-learning datapath. Per update request it:
- drives the 3-bit next-state select into the Max_Q multiplexer;
- waits for the shared gamma multiplier to settle, then registers the gamma·maxQ product;
- issues a one-hot update strobe to the single EN block owning the current action;
- counts completed steps per episode.

It sits between the environment/step controller and the six EN blocks.

## Interface
- MUL_LAT, 1: settle cycles allowed for the mux + multiplier path, ≥1.
- MAX_STEPS, 16'd1000: steps per episode, ≥1.
- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  update request; sampled only in IDLE.
- next_state  in  3  next-state index 0..5; sampled with start.
- cur_action  in  3  action index 0..5 to update; sampled with start.
- clr_cnt  in  1  synchronous clear of step counter.
- gamma_maxQ  in  24  product returned by the gamma multiplier.
- S_to_EN  out  3  mux select to the Max_Q multiplexer.
- target_q  out  24  registered gamma·maxQ, valid while upd_en is nonzero.
- upd_en  out  6  one-hot EN-block update strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done when either sampled index was ≥6.
- step_cnt  out  16  completed steps in current episode.
- episode_end  out  1  one-cycle pulse coincident with the done of step MAX_STEPS.

## Operation
- FSM states: IDLE → SEL → WAIT → UPD → DONE → IDLE.
- IDLE, start=1: latch next_state, cur_action and the invalid flags; go to SEL. IDLE, start=0: stay.
- SEL: drive S_to_EN; load wait counter with MUL_LAT−1; go to WAIT.
- WAIT: hold S_to_EN; decrement counter; at 0, register target_q ← gamma_maxQ and go to UPD.
- UPD: upd_en[cur_action]=1 for exactly one cycle; go to DONE.
- DONE: done=1; err=1 if either latched index ≥6; update step_cnt; go to IDLE.
- Invalid next_state (6, 7): S_to_EN driven 3'b000, matching the mux default.
- Invalid cur_action (6, 7): upd_en stays 0 in UPD; sequence otherwise completes normally.
- Step counter in DONE:
  - if step_cnt==MAX_STEPS−1: episode_end=1 and step_cnt←0;
  - else step_cnt+1.
  - Erroneous steps still count.
- clr_cnt: step_cnt←0 next edge in any state. It has priority over a DONE-cycle increment, and episode_end is suppressed in that cycle.
- start while busy: ignored, not queued.
- Latched inputs are immune to input changes after sampling.

## Timing
- Reset values: state IDLE, S_to_EN 0, target_q 0, upd_en 0, busy 0, done 0, err 0, step_cnt 0, episode_end 0.
- start sampled at edge 0. Then:
  - SEL during cycle 1;
  - WAIT during cycles 2..1+MUL_LAT;
  - UPD during cycle 2+MUL_LAT;
  - done during cycle 3+MUL_LAT.
- Latency start→done = 3+MUL_LAT cycles. Peak throughput is one update per 4+MUL_LAT cycles, since start in DONE is ignored.
- S_to_EN holds its value from SEL until the next SEL, including through IDLE.
- target_q holds until the next capture.
- gamma_maxQ must be stable by the last WAIT edge; the multiplier is combinational, so MUL_LAT=1 suffices unless timing forces more.
- RST assertion mid-sequence: all outputs return to reset values immediately and asynchronously. No done, upd_en or episode_end is emitted for the aborted step.
- All outputs are registered; none are combinational from inputs.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/SEL/WAIT/UPD/DONE);
  - NUM_ACTIONS=6, NUM_STATES=6;
  - Q_W=24, IDX_W=3.
- One sub-module is natural: step_counter (16-bit, clear, wrap at MAX_STEPS, episode_end pulse). Everything else stays in q_update_sched.
- The mux/multiplier pair stays external; this block only drives its select and samples its product.

## Test plan
- Reset, then start with next_state=2, cur_action=4, gamma_maxQ=24'h3F4000, MUL_LAT=1:
  - S_to_EN=2 from cycle 1;
  - upd_en=6'b010000 and target_q=24'h3F4000 in cycle 3;
  - done in cycle 4; step_cnt=1.
- next_state=7, cur_action=1: S_to_EN=0; upd_en=6'b000010; err=1 coincident with done.
- cur_action=6: upd_en stays 0 throughout; err=1 with done; step_cnt still increments.
- start held high continuously: updates complete every 5 cycles (MUL_LAT=1); no extra done pulses.
- MAX_STEPS=3 with three back-to-back updates: third done carries episode_end=1 and step_cnt→0. clr_cnt in a DONE cycle leaves step_cnt=0 with no episode_end.
- RST low during WAIT: outputs return to reset values immediately. No upd_en or done follows. The next start completes a normal sequence.
